// File: rtl/apb_subordinate_ni_if.sv
// Packet types for the APB subordinate network interface, and the APB bus interface
// that connects a local APB requester to it.

package apb_subordinate_ni_pkg;

    typedef struct packed {
        logic [14:0] data_bits;
    } flit_s;

    typedef struct packed {
        flit_s [3:0] body_flit;
    } req_packet_s;

    typedef struct packed {
        flit_s [2:0] body_flit;
    } resp_packet_s;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_WAIT,
        S_REQ_PUSH,
        S_RESP_WAIT,
        S_RESP_POP,
        S_RESP_CAP,
        S_DONE
    } state_e;

endpackage

interface apb_subordinate_ni_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_subordinate_ni.sv
// APB completer-side NI: packs one APB transfer into a request packet, waits for its response.
// Optional response watchdog enabled by defining SUB_NI_TIMEOUT_EN.

module apb_subordinate_ni
    import apb_subordinate_ni_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_subordinate_ni_if.slave  apb,
    output req_packet_s          req_pkt,
    input  logic                 req_fifo_full,
    output logic                 req_fifo_wreq,
    input  resp_packet_s         resp_pkt,
    input  logic                 resp_fifo_empty,
    output logic                 resp_fifo_rreq
);

    if (ADDR_W != 14 || DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_subordinate_ni: ADDR_W must be 14, DATA_W 32, TIMEOUT_CYCLES >= 1");
    end

    state_e      state;
    logic        is_write;
    logic        accept_setup;
    logic        access_phase;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        unused_resp_bits;

    function automatic req_packet_s pack_req(input logic             wr,
                                             input logic [ADDR_W-1:0] addr,
                                             input logic [DATA_W-1:0] wdata);
        req_packet_s       pkt;
        logic [DATA_W-1:0] wd;
        pkt = '0;
        wd  = wr ? wdata : '0;
        pkt.body_flit[0].data_bits              = {addr, wr};
        pkt.body_flit[1].data_bits              = wd[31:17];
        pkt.body_flit[2].data_bits              = wd[16:2];
        pkt.body_flit[3].data_bits[14:13]       = wd[1:0];
        return pkt;
    endfunction

    assign resp_rdata = {resp_pkt.body_flit[0].data_bits,
                         resp_pkt.body_flit[1].data_bits,
                         resp_pkt.body_flit[2].data_bits[14:13]};
    assign resp_err   = resp_pkt.body_flit[2].data_bits[12];
    assign unused_resp_bits = ^resp_pkt.body_flit[2].data_bits[11:0];

    assign access_phase = apb.PSEL & apb.PENABLE;

`ifdef SUB_NI_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             drop_pending;

    // A timed-out response still sits in the inbound FIFO; no new request until it is drained.
    assign accept_setup = apb.PSEL & ~apb.PENABLE & ~drop_pending;
`else
    assign accept_setup = apb.PSEL & ~apb.PENABLE;
`endif

    // NOTE: all state and registered outputs live in one clocked block and use non-blocking
    // assignments, so every branch reads the pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state          <= S_IDLE;
            is_write       <= 1'b0;
            req_pkt        <= '0;
            req_fifo_wreq  <= 1'b0;
            resp_fifo_rreq <= 1'b0;
            apb.PRDATA     <= '0;
            apb.PREADY     <= 1'b0;
            apb.PSLVERR    <= 1'b0;
`ifdef SUB_NI_TIMEOUT_EN
            wait_cnt       <= '0;
            drop_pending   <= 1'b0;
`endif
        end else begin
            req_fifo_wreq  <= 1'b0;
            resp_fifo_rreq <= 1'b0;

            case (state)
                S_IDLE: begin
`ifdef SUB_NI_TIMEOUT_EN
                    if (drop_pending && !resp_fifo_empty) begin
                        resp_fifo_rreq <= 1'b1;
                        drop_pending   <= 1'b0;
                    end
`endif
                    if (accept_setup) begin
                        req_pkt  <= pack_req(apb.PWRITE, apb.PADDR, apb.PWDATA);
                        is_write <= apb.PWRITE;
                        state    <= S_REQ_WAIT;
                    end
                end

                S_REQ_WAIT: begin
                    if (!req_fifo_full) begin
                        req_fifo_wreq <= 1'b1;
                        state         <= S_REQ_PUSH;
                    end
                end

                S_REQ_PUSH: begin
`ifdef SUB_NI_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_RESP_WAIT;
                end

                S_RESP_WAIT: begin
                    if (!resp_fifo_empty) begin
                        resp_fifo_rreq <= 1'b1;
                        state          <= S_RESP_POP;
                    end
`ifdef SUB_NI_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        apb.PRDATA   <= '0;
                        apb.PSLVERR  <= 1'b1;
                        apb.PREADY   <= access_phase;
                        drop_pending <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                // resp_pkt becomes valid one cycle after the pop pulse.
                S_RESP_POP: state <= S_RESP_CAP;

                S_RESP_CAP: begin
                    apb.PRDATA  <= is_write ? '0 : resp_rdata;
                    apb.PSLVERR <= resp_err;
                    apb.PREADY  <= access_phase;
                    state       <= S_DONE;
                end

                S_DONE: begin
                    // PREADY already high means this edge completes the access phase.
                    if (apb.PREADY || !apb.PSEL) begin
                        apb.PREADY  <= 1'b0;
                        apb.PRDATA  <= '0;
                        apb.PSLVERR <= 1'b0;
                        state       <= S_IDLE;
                    end else if (apb.PENABLE) begin
                        apb.PREADY <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_subordinate_ni.sv
// Directed, table-driven bench for apb_subordinate_ni with a cycle-level FIFO responder.

module tb_apb_subordinate_ni;
    import apb_subordinate_ni_pkg::*;

    logic         clk;
    logic         rst_n;
    req_packet_s  req_pkt;
    logic         req_fifo_full;
    logic         req_fifo_wreq;
    resp_packet_s resp_pkt;
    logic         resp_fifo_empty;
    logic         resp_fifo_rreq;

    int checks = 0;
    int errors = 0;

    apb_subordinate_ni_if #(.ADDR_W(14), .DATA_W(32)) apb ();

    apb_subordinate_ni #(
        .ADDR_W(14),
        .DATA_W(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK            (clk),
        .PRESETn         (rst_n),
        .apb             (apb),
        .req_pkt         (req_pkt),
        .req_fifo_full   (req_fifo_full),
        .req_fifo_wreq   (req_fifo_wreq),
        .resp_pkt        (resp_pkt),
        .resp_fifo_empty (resp_fifo_empty),
        .resp_fifo_rreq  (resp_fifo_rreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp_data;
        logic        rsp_err;
        int          full_cycles;
        logic [14:0] f0, f1, f2, f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_ready;
    } vec_t;

    typedef struct {
        int          ready_cyc;
        int          n_ready;
        int          n_wreq;
        int          n_rreq;
        logic [31:0] rdata;
        logic        err;
        req_packet_s pkt;
    } res_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic resp_packet_s pack_resp(input logic [31:0] data, input logic err);
        resp_packet_s p;
        p = '0;
        p.body_flit[0].data_bits = data[31:17];
        p.body_flit[1].data_bits = data[16:2];
        p.body_flit[2].data_bits = {data[1:0], err, 12'h000};
        return p;
    endfunction

    // One APB transfer; the responder loads a response after the push and presents it
    // the cycle after the pop. drop_at >= 0 abandons the transfer at that cycle.
    task automatic drive_xfer(input vec_t v, input int drop_at, input bit respond, output res_t r);
        int  done_at;
        bit  load_next;
        r.ready_cyc = -1;
        r.n_ready   = 0;
        r.n_wreq    = 0;
        r.n_rreq    = 0;
        r.rdata     = '0;
        r.err       = 1'b0;
        r.pkt       = '0;
        done_at     = -1;
        load_next   = 1'b0;
        @(negedge clk);
        apb.PSEL        = 1'b1;
        apb.PENABLE     = 1'b0;
        apb.PWRITE      = v.wr;
        apb.PADDR       = v.addr;
        apb.PWDATA      = v.wdata;
        resp_fifo_empty = 1'b1;
        resp_pkt        = '1;
        req_fifo_full   = (v.full_cycles > 0);
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (load_next) begin
                resp_pkt  = pack_resp(v.rsp_data, v.rsp_err);
                load_next = 1'b0;
            end
            if (cyc == 0) apb.PENABLE = 1'b1;
            req_fifo_full = (cyc < v.full_cycles);
            if (cyc == drop_at || (done_at >= 0 && cyc == done_at + 1)) begin
                apb.PSEL    = 1'b0;
                apb.PENABLE = 1'b0;
            end
            if (req_fifo_wreq) begin
                r.n_wreq++;
                r.pkt = req_pkt;
                if (respond) resp_fifo_empty = 1'b0;
            end
            if (resp_fifo_rreq) begin
                r.n_rreq++;
                resp_fifo_empty = 1'b1;
                load_next       = 1'b1;
            end
            if (apb.PREADY) begin
                r.n_ready++;
                if (done_at < 0) begin
                    done_at     = cyc;
                    r.ready_cyc = cyc;
                    r.rdata     = apb.PRDATA;
                    r.err       = apb.PSLVERR;
                end
            end
            if (done_at >= 0 && cyc == done_at + 3) break;
        end
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        res_t r;
        drive_xfer(v, -1, 1'b1, r);
        check({tag, " wreq count"}, 64'(r.n_wreq), 64'd1);
        check({tag, " req_pkt"}, 64'(r.pkt), 64'({v.f3, v.f2, v.f1, v.f0}));
        check({tag, " rreq count"}, 64'(r.n_rreq), 64'd1);
        check({tag, " ready cycle"}, 64'(r.ready_cyc), 64'(v.exp_ready));
        check({tag, " ready pulses"}, 64'(r.n_ready), 64'd1);
        check({tag, " PRDATA"}, 64'(r.rdata), 64'(v.exp_rdata));
        check({tag, " PSLVERR"}, 64'(r.err), 64'(v.exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        res_t r;
        int   n;

        // wr addr wdata rsp_data rsp_err full f0 f1 f2 f3 exp_rdata exp_err exp_ready
        vecs[0] = '{1'b1, 14'h1234, 32'hDEADBEEF, 32'h12345678, 1'b0, 0,
                    15'h2469, 15'h6F56, 15'h6FBB, 15'h6000, 32'h0, 1'b0, 5};
        vecs[1] = '{1'b0, 14'h0004, 32'hFFFFFFFF, 32'hA5A55A5A, 1'b1, 0,
                    15'h0008, 15'h0000, 15'h0000, 15'h0000, 32'hA5A55A5A, 1'b1, 5};
        vecs[2] = '{1'b1, 14'h3FFF, 32'h00000001, 32'hFFFFFFFF, 1'b1, 7,
                    15'h7FFF, 15'h0000, 15'h0000, 15'h2000, 32'h0, 1'b1, 12};
        vecs[3] = '{1'b0, 14'h2AAA, 32'h0, 32'h80000001, 1'b0, 0,
                    15'h5554, 15'h0000, 15'h0000, 15'h0000, 32'h80000001, 1'b0, 5};
        vecs[4] = '{1'b1, 14'h0000, 32'h80000002, 32'h0, 1'b0, 0,
                    15'h0001, 15'h4000, 15'h0000, 15'h4000, 32'h0, 1'b0, 5};

        rst_n           = 1'b1;
        apb.PSEL        = 1'b0;
        apb.PENABLE     = 1'b0;
        apb.PWRITE      = 1'b0;
        apb.PADDR       = '0;
        apb.PWDATA      = '0;
        req_fifo_full   = 1'b0;
        resp_fifo_empty = 1'b1;
        resp_pkt        = '0;
        #3 rst_n = 1'b0;
        #20;
        check("reset PREADY", 64'(apb.PREADY), 64'd0);
        check("reset PRDATA", 64'(apb.PRDATA), 64'd0);
        check("reset PSLVERR", 64'(apb.PSLVERR), 64'd0);
        check("reset wreq", 64'(req_fifo_wreq), 64'd0);
        check("reset rreq", 64'(resp_fifo_rreq), 64'd0);
        check("reset req_pkt", 64'(req_pkt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Setup with PENABLE already high must be ignored in IDLE.
        @(negedge clk);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b1;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = 14'h0F0F;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (req_fifo_wreq) n++;
        end
        check("bad setup wreq count", 64'(n), 64'd0);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        run_vec("after bad setup", vecs[3]);

        // PSEL dropped while waiting for the response.
        drive_xfer(vecs[1], 3, 1'b1, r);
        check("psel drop wreq count", 64'(r.n_wreq), 64'd1);
        check("psel drop rreq count", 64'(r.n_rreq), 64'd1);
        check("psel drop ready pulses", 64'(r.n_ready), 64'd0);
        run_vec("after psel drop", vecs[0]);

        // Asynchronous reset while in RESP_WAIT.
        @(negedge clk);
        apb.PSEL        = 1'b1;
        apb.PENABLE     = 1'b0;
        apb.PWRITE      = 1'b1;
        apb.PADDR       = 14'h0155;
        apb.PWDATA      = 32'h0;
        resp_fifo_empty = 1'b1;
        @(negedge clk);
        apb.PENABLE = 1'b1;
        repeat (4) @(negedge clk);
        check("pre-reset req_pkt", 64'(req_pkt), 64'h2AB);
        #2 rst_n = 1'b0;
        #1;
        check("async reset req_pkt", 64'(req_pkt), 64'd0);
        check("async reset PREADY", 64'(apb.PREADY), 64'd0);
        check("async reset wreq", 64'(req_fifo_wreq), 64'd0);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after reset", vecs[1]);

`ifdef SUB_NI_TIMEOUT_EN
        drive_xfer(vecs[3], -1, 1'b0, r);
        check("timeout ready cycle", 64'(r.ready_cyc), 64'd18);
        check("timeout PSLVERR", 64'(r.err), 64'd1);
        check("timeout PRDATA", 64'(r.rdata), 64'd0);
        check("timeout rreq count", 64'(r.n_rreq), 64'd0);
        @(negedge clk);
        resp_pkt        = pack_resp(32'hDEAD0000, 1'b0);
        resp_fifo_empty = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_fifo_rreq) begin
                n++;
                resp_fifo_empty = 1'b1;
            end
        end
        check("late drop rreq count", 64'(n), 64'd1);
        run_vec("after timeout", vecs[1]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_subordinate_ni.md
Name: apb_subordinate_ni

Overview:
- APB completer-side network interface, the counterpart to the APB manager NI.
- Accepts APB transfers from a local APB requester, packs each one into a req_packet_s, and pushes it into the outbound request FIFO.
- Pops the matching resp_packet_s from the inbound response FIFO, then completes the APB access phase with PRDATA/PSLVERR.
- One outstanding transfer at a time.

Parameters:
- ADDR_W, 14, PADDR width; fixed by flit packing, must be 14.
- DATA_W, 32, PWDATA/PRDATA width; fixed by flit packing, must be 32.
- TIMEOUT_CYCLES, 1024, response watchdog limit (used only with SUB_NI_TIMEOUT_EN).

Ports:
- PCLK  in  1  APB clock.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  14  APB address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- req_pkt  out  req_packet_s  request packet to outbound FIFO.
- req_fifo_full  in  1  outbound FIFO full.
- req_fifo_wreq  out  1  outbound FIFO push, 1-cycle pulse.
- resp_pkt  in  resp_packet_s  response packet from inbound FIFO; valid the cycle after resp_fifo_rreq.
- resp_fifo_empty  in  1  inbound FIFO empty.
- resp_fifo_rreq  out  1  inbound FIFO pop, 1-cycle pulse.

Behaviour:
- Reset: PRESETn is asynchronous, active-low; clock is PCLK. On reset:
  - State goes to IDLE.
  - PRDATA=0, PREADY=0, PSLVERR=0, req_fifo_wreq=0, resp_fifo_rreq=0, req_pkt=0.
  - Internal capture registers cleared.
  - Reset mid-transfer abandons the transfer; FIFO contents are not flushed.
- Request packing, captured at setup:
  - body_flit[0].data_bits[0] = PWRITE.
  - body_flit[0].data_bits[14:1] = PADDR.
  - body_flit[1].data_bits[14:0] = PWDATA[31:17].
  - body_flit[2].data_bits[14:0] = PWDATA[16:2].
  - body_flit[3].data_bits[14:13] = PWDATA[1:0].
  - All other bits 0; PWDATA field 0 for reads.
  - req_pkt is registered and held stable from capture through the push cycle.
- Response unpacking:
  - {body_flit[0].data_bits, body_flit[1].data_bits, body_flit[2].data_bits[14:13]} = PRDATA.
  - body_flit[2].data_bits[12] = PSLVERR.
- States:
  - IDLE: on PSEL=1 & PENABLE=0, capture PWRITE/PADDR/PWDATA and go to REQ_WAIT.
  - REQ_WAIT: stay while req_fifo_full=1; else go to REQ_PUSH.
  - REQ_PUSH: req_fifo_wreq=1 for exactly one cycle; go to RESP_WAIT.
  - RESP_WAIT: stay while resp_fifo_empty=1; else go to RESP_POP.
  - RESP_POP: resp_fifo_rreq=1 for one cycle; go to RESP_CAP.
  - RESP_CAP: register PRDATA (reads only; 0 for writes) and PSLVERR from resp_pkt; go to DONE.
  - DONE: if PSEL=1 & PENABLE=1, assert PREADY=1 with PRDATA/PSLVERR for one cycle, then go to IDLE. If PSEL=0, discard the response, drive PREADY=0, and go to IDLE.
- Outputs outside DONE: PREADY=0, PRDATA=0, PSLVERR=0. PREADY=0 while the access phase waits, extending it.
- Latency: setup observed at T0, PREADY at T5 minimum (no FIFO stalls).
- Back-to-back: a new setup is accepted only in IDLE, so the earliest next setup is sampled the cycle after PREADY.
- PSEL/PADDR changes after capture are ignored until IDLE.
- A setup with PENABLE already 1 is a protocol violation and is ignored in IDLE.

Optional Feature:
- Macro SUB_NI_TIMEOUT_EN.
- Enabled:
  - A counter clears on entering RESP_WAIT and increments each cycle there.
  - On reaching TIMEOUT_CYCLES with resp_fifo_empty=1, go to DONE with PSLVERR=1, PRDATA=0.
  - A drop_pending flag is set. While drop_pending=1 and resp_fifo_empty=0, IDLE pops one response (1-cycle rreq, not delivered) and clears the flag; new setups stall in IDLE until the flag clears.
- Disabled: RESP_WAIT waits indefinitely; no counter or flag logic.

Test Plan:
- Write PADDR=0x1234, PWDATA=0xDEADBEEF, FIFOs idle -> one wreq with flit0.data_bits=0x2469, flit1=0x6F56, flit2=0x6FBB, flit3[14:13]=2'b11. Response with PSLVERR=0 -> PREADY at T5, PSLVERR=0, PRDATA=0.
- Read PADDR=0x0004, response PRDATA=0xA5A5_5A5A, PSLVERR=1 -> exactly one rreq, PREADY one cycle, PRDATA=0xA5A55A5A, PSLVERR=1.
- req_fifo_full held 1 for 7 cycles after setup -> no wreq until full drops, wreq exactly once, PREADY stays 0 throughout.
- Assert PRESETn=0 during RESP_WAIT -> all outputs 0 immediately (asynchronous); next setup after release handled normally.
- PSEL dropped during RESP_WAIT -> response still popped once; PREADY never asserted; next transfer unaffected.
- SUB_NI_TIMEOUT_EN with TIMEOUT_CYCLES=16, no response -> PREADY with PSLVERR=1, PRDATA=0. Late response is silently popped; next read returns fresh data.
